// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: opcodes, mcause codes, trap FSM states,
// load-size funct3 encodings and the decode helpers used by the stage.
package wb_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   localparam logic [3:0] CAUSE_ECALL = 4'd11;
   localparam logic [3:0] CAUSE_SAM   = 4'd6;
   localparam logic [3:0] CAUSE_LAM   = 4'd4;
   localparam logic [3:0] CAUSE_SAF   = 4'd7;
   localparam logic [3:0] CAUSE_LAF   = 4'd5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      TFLUSH = 2'd1,
      TREDIR = 2'd2
   } wb_state_t;

   function automatic logic writes_rd(input logic [6:0] opc, input logic [2:0] f3);
      logic w;
      w = 1'b0;
      case (opc)
         OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32,
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: w = 1'b1;
         // SYSTEM with funct3 == 0 is ECALL/EBREAK/xRET, which never writes rd
         OPC_SYSTEM: w = (f3 != 3'b000);
         default: w = 1'b0;
      endcase
      return w;
   endfunction

   function automatic logic [3:0] trap_cause(input logic ecall, input logic sam,
                                             input logic lam, input logic saf,
                                             input logic laf);
      logic [3:0] c;
      c = 4'd0;
      if (ecall)    c = CAUSE_ECALL;
      else if (sam) c = CAUSE_SAM;
      else if (lam) c = CAUSE_LAM;
      else if (saf) c = CAUSE_SAF;
      else if (laf) c = CAUSE_LAF;
      return c;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data alignment: sign/zero-extends right-justified load data by funct3.
// funct3 = 3'b111 has no defined size and passes the raw data through.
module load_extend
   import wb_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] result
);

   always_comb begin
      result = raw;
      case (funct3)
         F3_LB:   result = {{(XLEN-8){raw[7]}},   raw[7:0]};
         F3_LH:   result = {{(XLEN-16){raw[15]}}, raw[15:0]};
         F3_LW:   result = {{(XLEN-32){raw[31]}}, raw[31:0]};
         F3_LD:   result = raw;
         F3_LBU:  result = {{(XLEN-8){1'b0}},     raw[7:0]};
         F3_LHU:  result = {{(XLEN-16){1'b0}},    raw[15:0]};
         F3_LWU:  result = {{(XLEN-32){1'b0}},    raw[31:0]};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: register write-back, branch/jump redirect and a RUN/TFLUSH/TREDIR trap
// sequencer. Define WB_INSTRET_EN to build the retired-instruction counter; otherwise INSTRET is 0.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int              XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            WB_V,
   input  logic [31:0]     WB_IR,
   input  logic [XLEN-1:0] WB_NPC,
   input  logic [XLEN-1:0] WB_ALU_RESULT,
   input  logic [XLEN-1:0] WB_MEM_RESULT,
   input  logic [XLEN-1:0] WB_CSRFD,
   input  logic            WB_PC_MUX,
   input  logic            WB_ECALL,
   input  logic            MEM_LAM,
   input  logic            MEM_LAF,
   input  logic            MEM_SAM,
   input  logic            MEM_SAF,
   input  logic [XLEN-1:0] CSR_MTVEC,
   input  logic            RF_BUSY,
   output logic            WB_STALL,
   output logic            RF_WE,
   output logic [4:0]      RF_WADDR,
   output logic [XLEN-1:0] RF_WDATA,
   output logic            PC_REDIRECT_V,
   output logic [XLEN-1:0] PC_REDIRECT_TARGET,
   output logic            FLUSH,
   output logic            TRAP_V,
   output logic [3:0]      TRAP_CAUSE,
   output logic [XLEN-1:0] TRAP_EPC,
   output logic [XLEN-1:0] INSTRET
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic            trap;
   logic            need_wr;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wb_data;
   logic [XLEN-1:0] epc_calc;
   logic            latch_trap;
   wb_state_t       state_q, state_d;
   logic            unused_bits;

   assign opcode   = WB_IR[6:0];
   assign rd       = WB_IR[11:7];
   assign funct3   = WB_IR[14:12];
   assign trap     = WB_V & (WB_ECALL | MEM_SAM | MEM_LAM | MEM_SAF | MEM_LAF);
   assign need_wr  = WB_V & writes_rd(opcode, funct3) & (rd != 5'd0);
   assign epc_calc = WB_NPC - XLEN'(4);

   assign unused_bits = ^{WB_IR[31:15], CSR_MTVEC[1:0], WB_ALU_RESULT[0]};

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .funct3 (funct3),
      .raw    (WB_MEM_RESULT),
      .result (load_data)
   );

   always_comb begin
      wb_data = WB_ALU_RESULT;
      case (opcode)
         OPC_LOAD:           wb_data = load_data;
         OPC_JAL, OPC_JALR:  wb_data = WB_NPC;
         OPC_SYSTEM:         wb_data = WB_CSRFD;
         default:            wb_data = WB_ALU_RESULT;
      endcase
   end

   assign RF_WADDR = rd;
   assign RF_WDATA = wb_data;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= RUN;
         TRAP_CAUSE <= 4'd0;
         TRAP_EPC   <= '0;
      end else begin
         state_q <= state_d;
         if (latch_trap) begin
            TRAP_CAUSE <= trap_cause(WB_ECALL, MEM_SAM, MEM_LAM, MEM_SAF, MEM_LAF);
            TRAP_EPC   <= epc_calc;
         end
      end
   end

   always_comb begin
      state_d            = state_q;
      latch_trap         = 1'b0;
      RF_WE              = 1'b0;
      WB_STALL           = 1'b0;
      PC_REDIRECT_V      = 1'b0;
      PC_REDIRECT_TARGET = {WB_ALU_RESULT[XLEN-1:1], 1'b0};
      FLUSH              = 1'b0;
      TRAP_V             = 1'b0;
      case (state_q)
         RUN: begin
            if (trap) begin
               // A trapping instruction neither writes nor redirects, even with RF_BUSY set
               state_d    = TFLUSH;
               latch_trap = 1'b1;
            end else if (WB_V) begin
               if (need_wr && RF_BUSY) begin
                  WB_STALL = 1'b1;
               end else begin
                  RF_WE         = need_wr;
                  PC_REDIRECT_V = WB_PC_MUX;
               end
            end
         end
         TFLUSH: begin
            FLUSH    = 1'b1;
            WB_STALL = 1'b1;
            state_d  = TREDIR;
         end
         TREDIR: begin
            PC_REDIRECT_V      = 1'b1;
            PC_REDIRECT_TARGET = {CSR_MTVEC[XLEN-1:2], 2'b00};
            TRAP_V             = 1'b1;
            WB_STALL           = 1'b1;
            state_d            = RUN;
         end
         default: state_d = RUN;
      endcase
      // Outputs must read as their reset values while RESET is held, not just after it
      if (RESET) begin
         RF_WE              = 1'b0;
         WB_STALL           = 1'b0;
         PC_REDIRECT_V      = 1'b0;
         PC_REDIRECT_TARGET = RESET_VECTOR;
         FLUSH              = 1'b0;
         TRAP_V             = 1'b0;
         latch_trap         = 1'b0;
      end
   end

`ifdef WB_INSTRET_EN
   logic            retire;
   logic [XLEN-1:0] instret_q;

   assign retire = (state_q == RUN) & WB_V & ~trap & ~WB_STALL;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)       instret_q <= '0;
      else if (retire) instret_q <= instret_q + XLEN'(1);
   end

   assign INSTRET = instret_q;
`else
   assign INSTRET = '0;
`endif

endmodule
